reconhecedor: RTL and testbench

Sequence recognizer that consumes a stream of 4-bit digits and tracks progress through the fixed 9-digit code 9-0-8-3-7-4-4-3-5. It produces the 5-bit position index of the match, the digit expected next, and pulses on full match or error. Repeated errors trigger a timed lockout. It is the input-side counterpart of the position-to-digit lookup used by the state machine display path: it turns digits back into a position index.

---
 rtl/reconhecedor.sv | 160 ++++++++++++++++
 tb/tb_reconhecedor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/reconhecedor.sv
// rtl/reconhecedor.sv - recognizer for the digit code 9-0-8-3-7-4-4-3-5 with timeout and lockout
module reconhecedor #(
    parameter int TIMEOUT     = 1000,
    parameter int MAX_ERROS   = 3,
    parameter int LOCK_CICLOS = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] digito,
    input  logic       valido,
    output logic [4:0] estado,
    output logic [3:0] esperado,
    output logic       aceito,
    output logic       erro,
    output logic       bloqueado
);

    localparam int IW = (TIMEOUT     > 1) ? $clog2(TIMEOUT)     : 1;
    localparam int EW = (MAX_ERROS   > 1) ? $clog2(MAX_ERROS)   : 1;
    localparam int LW = (LOCK_CICLOS > 1) ? $clog2(LOCK_CICLOS) : 1;

    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
    localparam logic [EW-1:0] ERR_LAST  = EW'(MAX_ERROS - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CICLOS - 1);

    typedef enum logic {ATIVO = 1'b0, BLOQUEADO = 1'b1} state_t;

    function automatic logic [3:0] code_at(input logic [4:0] pos);
        case (pos)
            5'd0:    code_at = 4'b1001;
            5'd1:    code_at = 4'b0000;
            5'd2:    code_at = 4'b1000;
            5'd3:    code_at = 4'b0011;
            5'd4:    code_at = 4'b0111;
            5'd5:    code_at = 4'b0100;
            5'd6:    code_at = 4'b0100;
            5'd7:    code_at = 4'b0011;
            5'd8:    code_at = 4'b0101;
            default: code_at = 4'b1001;
        endcase
    endfunction

    state_t        r_state;
    logic [4:0]    r_estado;
    logic [3:0]    r_esperado;
    logic          r_aceito;
    logic          r_erro;
    logic          r_bloqueado;
    logic [IW-1:0] r_idle;
    logic [EW-1:0] r_erros;
    logic [LW-1:0] r_lock;

    state_t        w_state_nx;
    logic [4:0]    w_estado_nx;
    logic [3:0]    w_esperado_nx;
    logic          w_aceito_nx;
    logic          w_erro_nx;
    logic          w_bloqueado_nx;
    logic [IW-1:0] w_idle_nx;
    logic [EW-1:0] w_erros_nx;
    logic [LW-1:0] w_lock_nx;
    logic          w_falha;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ATIVO;
            r_estado    <= 5'd0;
            r_esperado  <= 4'b1001;
            r_aceito    <= 1'b0;
            r_erro      <= 1'b0;
            r_bloqueado <= 1'b0;
            r_idle      <= '0;
            r_erros     <= '0;
            r_lock      <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_estado    <= w_estado_nx;
            r_esperado  <= w_esperado_nx;
            r_aceito    <= w_aceito_nx;
            r_erro      <= w_erro_nx;
            r_bloqueado <= w_bloqueado_nx;
            r_idle      <= w_idle_nx;
            r_erros     <= w_erros_nx;
            r_lock      <= w_lock_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_estado_nx = r_estado;
        w_idle_nx   = r_idle;
        w_erros_nx  = r_erros;
        w_lock_nx   = r_lock;
        w_aceito_nx = 1'b0;
        w_erro_nx   = 1'b0;
        w_falha     = 1'b0;
        case (r_state)
            ATIVO: begin
                if (valido) begin
                    w_idle_nx = '0;
                    if (digito == code_at(r_estado)) begin
                        if (r_estado == 5'd8) begin
                            w_estado_nx = 5'd0;
                            w_aceito_nx = 1'b1;
                            w_erros_nx  = '0;
                        end else begin
                            w_estado_nx = r_estado + 5'd1;
                        end
                    end else begin
                        // a stray 9 may be the start of a fresh attempt
                        w_estado_nx = (digito == 4'b1001) ? 5'd1 : 5'd0;
                        w_falha     = (r_estado != 5'd0);
                    end
                end else if (r_estado == 5'd0) begin
                    w_idle_nx = '0;
                end else if (r_idle == IDLE_LAST) begin
                    w_idle_nx   = '0;
                    w_estado_nx = 5'd0;
                    w_falha     = 1'b1;
                end else begin
                    w_idle_nx = r_idle + IW'(1);
                end

                if (w_falha) begin
                    w_erro_nx = 1'b1;
                    if (r_erros == ERR_LAST) begin
                        w_state_nx  = BLOQUEADO;
                        w_estado_nx = 5'd0;
                        w_lock_nx   = '0;
                        w_idle_nx   = '0;
                    end else begin
                        w_erros_nx = r_erros + EW'(1);
                    end
                end
            end
            BLOQUEADO: begin
                if (r_lock == LOCK_LAST) begin
                    w_state_nx = ATIVO;
                    w_lock_nx  = '0;
                    w_erros_nx = '0;
                end else begin
                    w_lock_nx = r_lock + LW'(1);
                end
            end
            default: w_state_nx = ATIVO;
        endcase
    end

    always_comb begin
        w_bloqueado_nx = (w_state_nx == BLOQUEADO);
        w_esperado_nx  = w_bloqueado_nx ? 4'b1111 : code_at(w_estado_nx);
    end

    assign estado    = r_estado;
    assign esperado  = r_esperado;
    assign aceito    = r_aceito;
    assign erro      = r_erro;
    assign bloqueado = r_bloqueado;

endmodule

// File: tb/tb_reconhecedor.sv
// tb/tb_reconhecedor.sv - scoreboard bench for the digit code recognizer
module tb_reconhecedor;

    typedef struct packed {
        logic [4:0] estado;
        logic       aceito;
        logic       erro;
        logic       bloqueado;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] digito;
    logic       valido;
    logic [4:0] estado;
    logic [3:0] esperado;
    logic       aceito;
    logic       erro;
    logic       bloqueado;

    logic [3:0] code_tb [0:8] = '{4'd9, 4'd0, 4'd8, 4'd3, 4'd7, 4'd4, 4'd4, 4'd3, 4'd5};

    exp_t       sb [$];
    exp_t       m_exp;
    logic [3:0] m_esp;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_step  = 0;

    reconhecedor #(.TIMEOUT(4), .MAX_ERROS(3), .LOCK_CICLOS(8)) dut (
        .clock     (clk),
        .reset     (reset),
        .digito    (digito),
        .valido    (valido),
        .estado    (estado),
        .esperado  (esperado),
        .aceito    (aceito),
        .erro      (erro),
        .bloqueado (bloqueado)
    );

    always #5 clk = ~clk;

    task automatic step(input logic v, input logic [3:0] d, input logic [4:0] es,
                        input logic a, input logic e, input logic b);
        exp_t x;
        @(negedge clk);
        valido = v;
        digito = d;
        x.estado = es;
        x.aceito = a;
        x.erro = e;
        x.bloqueado = b;
        sb.push_back(x);
    endtask

    task automatic check_reset(input string name);
        n_tests++;
        if (estado !== 5'd0 || esperado !== 4'b1001 || aceito !== 1'b0 ||
            erro !== 1'b0 || bloqueado !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got estado=%0d esperado=%b aceito=%b erro=%b bloqueado=%b, expected 0 1001 0 0 0",
                     name, estado, esperado, aceito, erro, bloqueado);
        end
    endtask

    task automatic async_reset(input string name);
        @(posedge clk);
        #3;
        reset  = 1'b1;
        valido = 1'b0;
        #1;
        check_reset(name);
        #2;
        reset = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            m_exp = sb.pop_front();
            m_esp = m_exp.bloqueado ? 4'b1111 : code_tb[m_exp.estado];
            n_step++;
            n_tests++;
            if (estado !== m_exp.estado || esperado !== m_esp || aceito !== m_exp.aceito ||
                erro !== m_exp.erro || bloqueado !== m_exp.bloqueado) begin
                n_fail++;
                $display("FAIL step %0d: got estado=%0d esperado=%b aceito=%b erro=%b bloqueado=%b, expected estado=%0d esperado=%b aceito=%b erro=%b bloqueado=%b",
                         n_step, estado, esperado, aceito, erro, bloqueado,
                         m_exp.estado, m_esp, m_exp.aceito, m_exp.erro, m_exp.bloqueado);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        reset  = 1'b1;
        valido = 1'b0;
        digito = 4'd0;
        #1;
        check_reset("power_on_reset");
        @(negedge clk);
        reset = 1'b0;

        // full code on consecutive cycles
        for (int i = 0; i < 9; i++)
            step(1'b1, code_tb[i], 5'((i == 8) ? 0 : i + 1), (i == 8), 1'b0, 1'b0);

        // mismatches mid-sequence, then completion clears the error count
        step(1'b1, 4'd9, 5'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd0, 5'd2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd7, 5'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'd9, 5'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd0, 5'd2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd9, 5'd1, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < 9; i++)
            step(1'b1, code_tb[i], 5'((i == 8) ? 0 : i + 1), (i == 8), 1'b0, 1'b0);

        // timeout on the 4th idle edge, then valido wins on the 4th idle cycle
        step(1'b1, 4'd9, 5'd1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 4'd0, 5'd1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'd9, 5'd1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 4'd0, 5'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd0, 5'd2, 1'b0, 1'b0, 1'b0);
        for (int i = 2; i < 9; i++)
            step(1'b1, code_tb[i], 5'((i == 8) ? 0 : i + 1), (i == 8), 1'b0, 1'b0);

        // non-9 digits at estado 0 are not errors; third real error locks
        step(1'b1, 4'd9, 5'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd1, 5'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'd3, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd3, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd9, 5'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd2, 5'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'd9, 5'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd3, 5'd0, 1'b0, 1'b1, 1'b1);

        // digits ignored during lockout; release 8 cycles after entry
        for (int k = 0; k < 7; k++) step(1'b1, 4'd9, 5'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 4'd9, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++)
            step(1'b1, code_tb[i], 5'((i == 8) ? 0 : i + 1), (i == 8), 1'b0, 1'b0);

        // asynchronous reset at estado 5
        for (int i = 0; i < 5; i++)
            step(1'b1, code_tb[i], 5'(i + 1), 1'b0, 1'b0, 1'b0);
        async_reset("reset_at_estado5");
        step(1'b1, 4'd9, 5'd1, 1'b0, 1'b0, 1'b0);

        // asynchronous reset during lockout clears the error count too
        step(1'b1, 4'd1, 5'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'd9, 5'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd1, 5'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'd9, 5'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd1, 5'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        async_reset("reset_in_lockout");
        step(1'b1, 4'd9, 5'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd1, 5'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'd9, 5'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd1, 5'd0, 1'b0, 1'b1, 1'b0);

        @(posedge clk);
        #3;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
